// File: rtl/kernel_fetch_ctrl.sv
// kernel_fetch_ctrl: walks a window of kernel-weight ROM addresses across a bank array and
// presents each ROM word slice to the MAC array under valid/ready. The ROM output register
// is the only data stage, so backpressure works by gating the ROM enables.
// Optional feature macro: KFC_REPEAT_EN (adds repeat_count input; the window is replayed
// repeat_count+1 times with no bubble between passes).
module kernel_fetch_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 736,
  parameter int unsigned NUM    = 512,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [NUM-1:0]    bank_mask,
`ifdef KFC_REPEAT_EN
  input  logic [7:0]        repeat_count,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM-1:0]    rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              out_valid,
  input  logic              out_ready
);

  // Reject configurations whose address bus cannot cover a bank.
  if (((2 ** ADDR_W) < DEPTH) || (WIDTH == 0)) begin : g_bad_cfg
    $error("kernel_fetch_ctrl: ADDR_W too small for DEPTH, or WIDTH is zero");
  end

  localparam logic [ADDR_W+1:0] DepthW = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   RemOne = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [NUM-1:0]      mask_q, mask_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                issue;
  logic [ADDR_W+1:0]   win_end;
`ifdef KFC_REPEAT_EN
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [7:0]          rep_q, rep_d;
  logic [7:0]          pass_q, pass_d;
`endif

  // One past the last word of the requested window, wide enough not to overflow.
  assign win_end = {2'b00, base_addr} + {1'b0, length};

  // Next-state logic: command acceptance, address issue and handshake tracking.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    issue   = 1'b0;
`ifdef KFC_REPEAT_EN
    base_d  = base_q;
    len_d   = len_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else if (win_end > DepthW) begin
            err_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = length;
            mask_d  = bank_mask;
            state_d = StFetch;
`ifdef KFC_REPEAT_EN
            base_d  = base_addr;
            len_d   = length;
            rep_d   = repeat_count;
            pass_d  = '0;
`endif
          end
        end
      end
      StFetch: begin
        // Issue only when the ROM output register is free or being drained this cycle.
        issue = !valid_q || out_ready;
        if (issue) begin
          valid_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == RemOne) begin
`ifdef KFC_REPEAT_EN
            if (pass_q != rep_q) begin
              pass_d = pass_q + 8'd1;
              addr_d = base_q;
              rem_d  = len_q;
            end else begin
              state_d = StDrain;
            end
`else
            state_d = StDrain;
`endif
          end
        end
      end
      StDrain: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef KFC_REPEAT_EN
      base_q  <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef KFC_REPEAT_EN
      base_q  <= base_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
`endif
    end
  end

  // Outputs: enables only on issue cycles so stalled ROMs hold their dout.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    err       = err_q;
    rom_en    = issue ? mask_q : '0;
    rom_addr  = addr_q;
    out_valid = valid_q;
  end

endmodule
